// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the modulo-N counter family.
//   cnt_dir_e  : direction encoding for the up_dn input (CNT_DN / CNT_UP).
//   clamp_load : limits a load value to the top of the count range, so a
//                counter can never be loaded outside 0..modulus-1.
package counter_pkg;

  typedef enum logic {
    CNT_DN = 1'b0,
    CNT_UP = 1'b1
  } cnt_dir_e;

  // Operates on 32-bit values so any counter width up to 31 bits can share it;
  // callers zero-extend their data in and truncate the result back.
  function automatic logic [31:0] clamp_load(input logic [31:0] d,
                                             input int unsigned modulus);
    logic [31:0] top;
    top = 32'(modulus - 1);
    return (d > top) ? top : d;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter: synchronous modulo-N up/down counter with parallel load,
// optional saturate-at-terminal mode, cascadable ripple-carry and a
// registered wrap pulse.
//
// Parameters:
//   WIDTH   - counter width in bits (2..31)
//   MODULUS - count range 0..MODULUS-1 (2..2**WIDTH)
// Ports:
//   clk   in  : clock, all state changes on the rising edge
//   clr   in  : synchronous active-high reset / clear (q=0, wrap=0)
//   ld_n  in  : synchronous load, active-low (d clamped to MODULUS-1)
//   enp   in  : parallel count enable
//   ent   in  : trickle count enable, also gates rco
//   up_dn in  : 1 = count up, 0 = count down
//   sat   in  : 1 = hold at terminal value instead of wrapping
//   d     in  : load data
//   q     out : current count
//   rco   out : combinational ripple-carry, ent & (q == terminal)
//   wrap  out : registered pulse, high while q shows the post-wrap value
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODULUS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld_n,
  input  logic             enp,
  input  logic             ent,
  input  logic             up_dn,
  input  logic             sat,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > 31) begin : g_bad_width
    $error("mod_counter: WIDTH must be in 2..31");
  end
  if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
    $error("mod_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             count_up;
  logic             at_term;

  assign count_up = (up_dn == CNT_UP);
  assign at_term  = count_up ? (q_q == MaxVal) : (q_q == '0);

  // Clear is handled in the register block; this covers load > count > hold.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (!ld_n) begin
      q_d = WIDTH'(clamp_load(32'(d), MODULUS));
    end else if (enp && ent) begin
      if (at_term) begin
        if (!sat) begin
          q_d    = count_up ? '0 : MaxVal;
          wrap_d = 1'b1;
        end
      end else begin
        q_d = count_up ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign rco  = ent & at_term;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter (WIDTH=4, MODULUS=10): directed scenarios, randomized
// traffic against an integer modulo-arithmetic reference, and a two-stage
// decade cascade checked against a plain 0..99 count.
module tb_mod_counter;

  localparam int unsigned W = 4;
  localparam int unsigned M = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         clr, ld_n, enp, ent, up_dn, sat;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         rco, wrap;

  mod_counter #(.WIDTH(W), .MODULUS(M)) u_dut (
    .clk(clk), .clr(clr), .ld_n(ld_n), .enp(enp), .ent(ent),
    .up_dn(up_dn), .sat(sat), .d(d), .q(q), .rco(rco), .wrap(wrap)
  );

  // Cascade pair: stage0 rco drives stage1 ent.
  logic         c_clr, c_enp;
  logic [W-1:0] c_q0, c_q1;
  logic         c_rco0, c_rco1, c_wrap0, c_wrap1;

  mod_counter #(.WIDTH(W), .MODULUS(M)) u_s0 (
    .clk(clk), .clr(c_clr), .ld_n(1'b1), .enp(c_enp), .ent(1'b1),
    .up_dn(1'b1), .sat(1'b0), .d('0), .q(c_q0), .rco(c_rco0), .wrap(c_wrap0)
  );
  mod_counter #(.WIDTH(W), .MODULUS(M)) u_s1 (
    .clk(clk), .clr(c_clr), .ld_n(1'b1), .enp(c_enp), .ent(c_rco0),
    .up_dn(1'b1), .sat(1'b0), .d('0), .q(c_q1), .rco(c_rco1), .wrap(c_wrap1)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference state: count as a plain integer, wrap flag, validity after clr.
  int unsigned m_q    = 0;
  bit          m_wrap = 1'b0;
  bit          m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Next state from the rules in integer terms: move one step around the
  // 0..M-1 ring; a step that crosses the ring seam is a wrap, which
  // saturate mode refuses (hold, no pulse).
  task automatic model_step(input bit c, input bit l_n, input bit ep,
                            input bit et, input bit u, input bit s,
                            input int unsigned dv);
    int unsigned nxt;
    bit crossed;
    if (c) begin
      m_q = 0; m_wrap = 0; m_valid = 1;
    end else if (!l_n) begin
      m_q = (dv > M - 1) ? M - 1 : dv; m_wrap = 0;
    end else if (ep && et) begin
      nxt     = u ? (m_q + 1) % M : (m_q + M - 1) % M;
      crossed = u ? (nxt < m_q) : (nxt > m_q);
      if (crossed && s) m_wrap = 0;
      else begin
        m_q = nxt; m_wrap = crossed;
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  // One clock: drive inputs, check combinational rco against the current
  // reference count, clock, then check q and wrap.
  task automatic cyc(input bit c, input bit l_n, input bit ep, input bit et,
                     input bit u, input bit s, input int unsigned dv);
    clr = c; ld_n = l_n; enp = ep; ent = et; up_dn = u; sat = s; d = W'(dv);
    #1;
    if (m_valid)
      check("rco", 32'(rco), 32'(et && (m_q == (u ? M - 1 : 0))));
    model_step(c, l_n, ep, et, u, s, dv);
    @(posedge clk);
    #1;
    check("q", 32'(q), 32'(m_q));
    check("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  initial begin
    int unsigned up_seq [4] = '{8, 9, 0, 1};
    int unsigned dn_seq [4] = '{1, 0, 0, 0};
    clr = 1'b0; ld_n = 1'b1; enp = 1'b0; ent = 1'b0;
    up_dn = 1'b1; sat = 1'b0; d = '0;
    c_clr = 1'b1; c_enp = 1'b0;
    @(posedge clk);
    #1;

    // Reset with a competing load; then rco with ent=1, down, at q=0.
    cyc(1, 0, 1, 1, 0, 0, 7);
    check("rst_q", 32'(q), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    clr = 0; ld_n = 1; enp = 0; ent = 1; up_dn = 0; #1;
    check("rst_rco", 32'(rco), 32'd1);

    // Load, clamp, load with enables off.
    cyc(0, 0, 1, 1, 1, 0, 6);
    check("load6", 32'(q), 32'd6);
    cyc(0, 0, 0, 0, 1, 0, 13);
    check("load_clamp", 32'(q), 32'd9);

    // Up count with wrap from 7.
    cyc(0, 0, 0, 0, 1, 0, 7);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 1, 1, 0, 0);
      check("up_seq", 32'(q), 32'(up_seq[i]));
      check("up_wrap", 32'(wrap), 32'(up_seq[i] == 0));
    end

    // Down count saturating at 0.
    cyc(0, 0, 0, 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 1, 0, 1, 0);
      check("dn_seq", 32'(q), 32'(dn_seq[i]));
      check("dn_wrap", 32'(wrap), 32'd0);
    end
    #1 check("sat_rco", 32'(rco), 32'd1);

    // Enables: either one low holds.
    cyc(0, 0, 0, 0, 1, 0, 5);
    cyc(0, 1, 0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 1, 0, 0);
    check("hold", 32'(q), 32'd5);

    // Priority at terminal: load beats wrap, clr beats everything.
    cyc(0, 0, 0, 0, 1, 0, 9);
    cyc(0, 0, 1, 1, 1, 0, 3);
    check("ld_over_cnt", 32'(q), 32'd3);
    check("ld_no_wrap", 32'(wrap), 32'd0);
    cyc(0, 0, 0, 0, 1, 0, 9);
    cyc(1, 0, 1, 1, 1, 0, 3);
    check("clr_over_all", 32'(q), 32'd0);

    // Randomized traffic; sat/direction change freely mid-count.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
          $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
          $urandom_range(0, 15));
    end

    // Cascade: two decades count 25 edges from 00.
    c_clr = 1'b1; c_enp = 1'b1;
    @(posedge clk); #1;
    c_clr = 1'b0;
    check("casc_rst", 32'(c_q1 * 10 + c_q0), 32'd0);
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #1;
      check("casc_cnt", 32'(c_q1 * 10 + c_q0), 32'(e % 100));
    end
    check("casc_s1", 32'(c_q1), 32'd2);
    check("casc_s0", 32'(c_q0), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised synchronous modulo-N up/down counter, the generalised successor of the 4-bit binary counter stage used for baud-rate division and bit counting in the UART datapath. Adds configurable width and modulus, an up/down direction input, and an optional saturate-at-terminal (one-shot) mode. Adds a registered wrap pulse alongside the cascadable combinational ripple-carry. Stages chain through `rco` → `ent` exactly as the discrete counter parts do.

## Interface
- `WIDTH`, default 8: counter width in bits, ≥ 2.
- `MODULUS`, default 2**WIDTH: count range 0..MODULUS-1; constraint 2 ≤ MODULUS ≤ 2**WIDTH.
- `clk` input 1: single clock; all state changes on rising edge.
- `clr` input 1: reset, synchronous, active-high; also serves as the functional synchronous clear.
- `ld_n` input 1: synchronous load, active-low.
- `enp` input 1: count enable (parallel), active-high.
- `ent` input 1: count enable (trickle), active-high; also gates `rco`.
- `up_dn` input 1: direction; 1 = count up, 0 = count down.
- `sat` input 1: 1 = hold at terminal value instead of wrapping.
- `d` input WIDTH: load data.
- `q` output WIDTH: current count.
- `rco` output 1: ripple-carry, combinational: `ent` & terminal.
- `wrap` output 1: registered one-cycle pulse, high the cycle after `q` wrapped.

## Operation
- Terminal value: MODULUS-1 when `up_dn`=1, 0 when `up_dn`=0. Terminal is evaluated against the current `q` and current `up_dn`.
- Priority per edge: `clr` > load (`ld_n`=0) > count (`enp`&`ent`) > hold.
- `clr`=1: `q`←0 and `wrap`←0, regardless of all other inputs.
- Load: `q`←`d` if `d` ≤ MODULUS-1, else `q`←MODULUS-1 (clamped). `wrap`←0. Load ignores `enp`, `ent` and `sat`.
- Count up: if `q` ≠ MODULUS-1 then `q`←`q`+1. At MODULUS-1:
  - `sat`=0: `q`←0 and `wrap`←1.
  - `sat`=1: `q` holds and `wrap`←0.
- Count down: if `q` ≠ 0 then `q`←`q`-1. At 0:
  - `sat`=0: `q`←MODULUS-1 and `wrap`←1.
  - `sat`=1: `q` holds and `wrap`←0.
- Any cycle that is not a wrapping count: `wrap`←0.
- Hold (`enp`=0 or `ent`=0, no clr/load): `q` and the internal state unchanged.
- `rco` = `ent` & (`q` == terminal). It is independent of `enp`, `clr`, `ld_n` and `sat`, so it stays asserted while saturated.
- Arithmetic is WIDTH-bit unsigned. `q` never leaves 0..MODULUS-1 by any input sequence.
- Direction or `sat` change mid-count takes effect on the next edge; no internal direction state exists.

## Timing
- After the first edge with `clr`=1: `q`=0, `wrap`=0. `rco` = `ent` & !`up_dn` (since `q`=0 is terminal only when counting down).
- Before the first `clr`, outputs are undefined; benches must apply `clr` first.
- Load/count latency: `q` updates on the edge sampling the control; visible one cycle after control is applied.
- `rco` has zero latency from `q`, `ent` and `up_dn`.
- `wrap` is high during exactly the cycle in which `q` shows the post-wrap value (0 up, MODULUS-1 down).
- `clr` asserted mid-count: overrides that edge; a pending wrap is suppressed.
- Simultaneous `clr` and `ld_n`=0: clear wins.
- Simultaneous load and terminal count: load wins, no `wrap`.
- Cascade: stage k `ent` = stage k-1 `rco`, all `enp` common. Higher stage advances on the same edge the lower stage wraps; no extra cycle per stage.

## Structure
- Package `counter_pkg`: direction constants `CNT_DN`=1'b0 and `CNT_UP`=1'b1. It also holds a function `clamp_load(d, MODULUS)`, shared with the future cascaded divider.
- Single module; no sub-module. A separate `mod_counter_chain` wrapper (N stages via `rco`→`ent`) is a later block, not part of this one.
- Elaboration-time check errors if MODULUS < 2 or MODULUS > 2**WIDTH.

## Test plan
All scenarios use WIDTH=4, MODULUS=10 unless stated.
- Reset: apply `clr`=1 with `ld_n`=0, `d`=7 → `q`=0, `wrap`=0. With `ent`=1, `up_dn`=0 → `rco`=1.
- Load: `ld_n`=0, `d`=6 → `q`=6. Then `d`=13 → `q`=9 (clamp). Load with `enp`=`ent`=0 still loads.
- Up count, wrap: from 7, `up_dn`=1, `sat`=0, count 4 edges → `q` = 8,9,0,1. `rco`=1 only while `q`=9. `wrap`=1 only while `q`=0.
- Down count, saturate: load 2, `up_dn`=0, `sat`=1, count 4 edges → `q` = 1,0,0,0. `wrap` stays 0. `rco` stays 1 from `q`=0 on.
- Enables and priority: `enp`=0 or `ent`=0 → `q` holds and `rco` follows `ent`. At `q`=9 counting up, load `d`=3 with `ld_n`=0 → `q`=3, `wrap`=0. Asserting `clr` on the same edge instead → `q`=0.
- Cascade: two stages, WIDTH=4, MODULUS=10, stage0 `rco` → stage1 `ent`, count up from 00 for 25 edges → {stage1,stage0} = 2,5. Stage1 increments on the same edge stage0 goes 9→0.
